// File: rtl/rgmii_pkg.sv
// Shared definitions for the RGMII link controller:
// FSM state encoding, speed codes and the decoded status bundle.
package rgmii_pkg;

    typedef enum logic [1:0] {
        ST_DOWN,
        ST_RESET,
        ST_UP,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] SPD_10   = 2'b00;
    localparam logic [1:0] SPD_100  = 2'b01;
    localparam logic [1:0] SPD_1000 = 2'b10;
    localparam logic [1:0] SPD_INV  = 2'b11;

    typedef struct packed {
        logic       link;
        logic [1:0] speed;
        logic       duplex;
    } link_status_t;

    localparam int LS_W = $bits(link_status_t);

endpackage

// File: rtl/link_status_debounce.sv
// Holds the latest in-band status as a candidate and flags it qualified
// once it has stayed unchanged for DEBOUNCE_CYC cycles.
module link_status_debounce
    import rgmii_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic            clk375,
    input  logic            rst,
    input  logic [LS_W-1:0] raw,
    output logic [LS_W-1:0] cand,
    output logic            qual
);

    localparam int SW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE_CYC - 1);

    logic [SW-1:0] stab_cnt;

    always_ff @(posedge clk375 or posedge rst) begin
        if (rst) begin
            cand     <= '0;
            stab_cnt <= '0;
        end else if (raw != cand) begin
            cand     <= raw;
            stab_cnt <= '0;
        end else if (stab_cnt != STAB_MAX) begin
            stab_cnt <= stab_cnt + 1'b1;
        end
    end

    assign qual = (stab_cnt == STAB_MAX);

endmodule

// File: rtl/rgmii_link_ctrl.sv
// Sequences the RGMII MAC around PHY link changes: debounce, drain TX,
// hold MAC in reset while speed/duplex are re-applied.
module rgmii_link_ctrl
    import rgmii_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 16,
    parameter int RST_CYC      = 8,
    parameter int DRAIN_TMO    = 1024
) (
    input  logic       clk375,
    input  logic       rst,
    input  logic       link_up_in,
    input  logic [1:0] speed_in,
    input  logic       duplex_in,
    input  logic       tx_busy,
    output logic       mac_rst,
    output logic       tx_enable,
    output logic [1:0] cfg_speed,
    output logic       cfg_duplex,
    output logic       link_ok,
    output logic       drain_tmo,
    output logic [7:0] change_cnt
);

    localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam int DW = (DRAIN_TMO > 1) ? $clog2(DRAIN_TMO) : 1;
    localparam logic [RW-1:0] RST_LAST   = RW'(RST_CYC - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TMO - 1);

    logic [LS_W-1:0] raw;
    logic [LS_W-1:0] cand_bits;
    logic [LS_W-1:0] applied;
    link_status_t    cand;
    logic            qual;
    logic            good;
    logic            diff;

    state_t          state;
    logic [RW-1:0]   rst_cnt;
    logic [DW-1:0]   drain_cnt;

    assign raw = {link_up_in, speed_in, duplex_in};

    link_status_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk375(clk375),
        .rst   (rst),
        .raw   (raw),
        .cand  (cand_bits),
        .qual  (qual)
    );

    assign cand    = cand_bits;
    assign good    = cand.link && (cand.speed != SPD_INV);
    assign applied = {1'b1, cfg_speed, cfg_duplex};
    assign diff    = qual && (cand_bits != applied);

    // Outputs are registered alongside the state, so each branch sets
    // the output values belonging to the state being entered.
    always_ff @(posedge clk375 or posedge rst) begin
        if (rst) begin
            state      <= ST_DOWN;
            mac_rst    <= 1'b1;
            tx_enable  <= 1'b0;
            cfg_speed  <= SPD_10;
            cfg_duplex <= 1'b0;
            link_ok    <= 1'b0;
            drain_tmo  <= 1'b0;
            change_cnt <= '0;
            rst_cnt    <= '0;
            drain_cnt  <= '0;
        end else begin
            drain_tmo <= 1'b0;
            unique case (state)
                ST_DOWN: begin
                    if (qual && good) begin
                        state      <= ST_RESET;
                        cfg_speed  <= cand.speed;
                        cfg_duplex <= cand.duplex;
                        rst_cnt    <= '0;
                    end
                end
                ST_RESET: begin
                    if (diff) begin
                        state <= ST_DOWN;
                    end else if (rst_cnt == RST_LAST) begin
                        state     <= ST_UP;
                        mac_rst   <= 1'b0;
                        tx_enable <= 1'b1;
                        link_ok   <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                ST_UP: begin
                    if (diff) begin
                        state     <= ST_DRAIN;
                        tx_enable <= 1'b0;
                        link_ok   <= 1'b0;
                        drain_cnt <= '0;
                        if (change_cnt != 8'hFF)
                            change_cnt <= change_cnt + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    // A clean drain wins over a timeout on the same cycle.
                    if (!tx_busy) begin
                        state   <= ST_DOWN;
                        mac_rst <= 1'b1;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        state     <= ST_DOWN;
                        mac_rst   <= 1'b1;
                        drain_tmo <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= ST_DOWN;
            endcase
        end
    end

endmodule

// File: tb/tb_rgmii_link_ctrl.sv
// Randomized and directed bench for rgmii_link_ctrl with a behavioural
// model compared every cycle plus hand-computed milestone checks.
module tb_rgmii_link_ctrl;

    localparam int DEB = 16;
    localparam int RC  = 8;
    localparam int DT  = 64;

    localparam int M_DOWN  = 0;
    localparam int M_RESET = 1;
    localparam int M_UP    = 2;
    localparam int M_DRAIN = 3;

    logic       clk375 = 1'b0;
    logic       rst;
    logic       link_up_in;
    logic [1:0] speed_in;
    logic       duplex_in;
    logic       tx_busy;
    logic       mac_rst;
    logic       tx_enable;
    logic [1:0] cfg_speed;
    logic       cfg_duplex;
    logic       link_ok;
    logic       drain_tmo;
    logic [7:0] change_cnt;

    int checks   = 0;
    int failures = 0;
    bit run_chk  = 0;

    rgmii_link_ctrl #(
        .DEBOUNCE_CYC(DEB),
        .RST_CYC     (RC),
        .DRAIN_TMO   (DT)
    ) dut (
        .clk375    (clk375),
        .rst       (rst),
        .link_up_in(link_up_in),
        .speed_in  (speed_in),
        .duplex_in (duplex_in),
        .tx_busy   (tx_busy),
        .mac_rst   (mac_rst),
        .tx_enable (tx_enable),
        .cfg_speed (cfg_speed),
        .cfg_duplex(cfg_duplex),
        .link_ok   (link_ok),
        .drain_tmo (drain_tmo),
        .change_cnt(change_cnt)
    );

    always #5 clk375 = ~clk375;

    // Behavioural model: status history queue, state, applied config.
    logic [3:0] hist[$];
    int         m_st;
    int         cyc;
    int         entry;
    logic [1:0] m_spd;
    logic       m_dup;
    int         m_chg;
    bit         m_tmo;

    always @(posedge clk375 or posedge rst) begin
        logic [3:0] c;
        bit q, g, d, same;
        if (rst) begin
            m_st  = M_DOWN;
            m_spd = 2'b00;
            m_dup = 1'b0;
            m_chg = 0;
            m_tmo = 0;
            cyc   = 0;
            entry = 0;
            hist.delete();
            hist.push_back(4'b0000);
        end else begin
            cyc++;
            c = hist[hist.size()-1];
            same = 1;
            foreach (hist[i]) if (hist[i] != c) same = 0;
            q = same && (hist.size() == DEB);
            g = c[3] && (c[2:1] != 2'b11);
            d = q && (c != {1'b1, m_spd, m_dup});
            m_tmo = 0;
            case (m_st)
                M_DOWN: if (q && g) begin
                    m_st  = M_RESET;
                    m_spd = c[2:1];
                    m_dup = c[0];
                    entry = cyc;
                end
                M_RESET: begin
                    if (d) m_st = M_DOWN;
                    else if (cyc - entry == RC) m_st = M_UP;
                end
                M_UP: if (d) begin
                    m_st  = M_DRAIN;
                    entry = cyc;
                    if (m_chg < 255) m_chg++;
                end
                default: begin
                    if (!tx_busy) m_st = M_DOWN;
                    else if (cyc - entry == DT) begin
                        m_st  = M_DOWN;
                        m_tmo = 1;
                    end
                end
            endcase
            hist.push_back({link_up_in, speed_in, duplex_in});
            if (hist.size() > DEB) void'(hist.pop_front());
        end
    end

    always @(negedge clk375) begin
        logic e_rst, e_en, e_ok;
        if (run_chk) begin
            e_rst = (m_st == M_DOWN) || (m_st == M_RESET);
            e_en  = (m_st == M_UP);
            e_ok  = (m_st == M_UP);
            checks++;
            if (mac_rst !== e_rst || tx_enable !== e_en ||
                cfg_speed !== m_spd || cfg_duplex !== m_dup ||
                link_ok !== e_ok || drain_tmo !== m_tmo ||
                change_cnt !== 8'(m_chg)) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t act=%b%b%0d%b%b%b/%0d exp=%b%b%0d%b%b%b/%0d",
                         $time, mac_rst, tx_enable, cfg_speed, cfg_duplex,
                         link_ok, drain_tmo, change_cnt, e_rst, e_en, m_spd,
                         m_dup, e_ok, m_tmo, m_chg);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk375);
        #1;
    endtask

    task automatic set_raw(input logic l, input logic [1:0] s, input logic d);
        link_up_in = l;
        speed_in   = s;
        duplex_in  = d;
    endtask

    initial begin
        rst = 1'b0;
        set_raw(1'b0, 2'b00, 1'b0);
        tx_busy = 1'b0;
        #1 rst = 1'b1;
        tick(2);
        run_chk = 1;
        chk("rst_mac_rst", 32'(mac_rst), 1);
        chk("rst_tx_en", 32'(tx_enable), 0);
        chk("rst_cnt", 32'(change_cnt), 0);

        // Bring-up: edge 0 is the first edge after release.
        set_raw(1'b1, 2'b10, 1'b1);
        rst = 1'b0;
        tick(16);
        chk("t1_down_e15", 32'(cfg_speed), 0);
        tick(1);
        chk("t1_reset_spd", 32'(cfg_speed), 2);
        chk("t1_reset_dup", 32'(cfg_duplex), 1);
        tick(7);
        chk("t1_reset_e23", 32'(mac_rst), 1);
        tick(1);
        chk("t1_up_mac", 32'(mac_rst), 0);
        chk("t1_up_en", 32'(tx_enable), 1);

        // Short speed glitch is filtered.
        speed_in = 2'b01;
        tick(10);
        speed_in = 2'b10;
        tick(30);
        chk("t2_up", 32'(link_ok), 1);
        chk("t2_cnt", 32'(change_cnt), 0);

        // Speed change with TX busy for the first DRAIN cycles.
        speed_in = 2'b01;
        tx_busy  = 1'b1;
        tick(16);
        chk("t3_still_up", 32'(link_ok), 1);
        tick(1);
        chk("t3_drain_ok", 32'(link_ok), 0);
        chk("t3_drain_mac", 32'(mac_rst), 0);
        chk("t3_cnt", 32'(change_cnt), 1);
        tick(4);
        chk("t3_drain_e20", 32'(mac_rst), 0);
        tx_busy = 1'b0;
        tick(1);
        chk("t3_down", 32'(mac_rst), 1);
        tick(1);
        chk("t3_reset_spd", 32'(cfg_speed), 1);
        tick(7);
        chk("t3_reset_e29", 32'(link_ok), 0);
        tick(1);
        chk("t3_up", 32'(link_ok), 1);

        // Link loss with TX stuck busy: timeout pulse.
        link_up_in = 1'b0;
        tx_busy    = 1'b1;
        tick(17);
        chk("t4_drain", 32'(link_ok), 0);
        chk("t4_cnt", 32'(change_cnt), 2);
        tick(63);
        chk("t4_pre_tmo", 32'(drain_tmo), 0);
        tick(1);
        chk("t4_tmo", 32'(drain_tmo), 1);
        chk("t4_tmo_mac", 32'(mac_rst), 1);
        tick(1);
        chk("t4_tmo_pulse", 32'(drain_tmo), 0);
        tick(50);
        chk("t4_stay_down", 32'(mac_rst), 1);
        tx_busy = 1'b0;

        // tx_busy drops on the timeout cycle: clean exit.
        link_up_in = 1'b1;
        tick(30);
        chk("tb_up", 32'(link_ok), 1);
        link_up_in = 1'b0;
        tx_busy    = 1'b1;
        tick(80);
        tx_busy = 1'b0;
        tick(1);
        chk("tb_no_pulse", 32'(drain_tmo), 0);
        chk("tb_down", 32'(mac_rst), 1);

        // Invalid speed never qualifies.
        set_raw(1'b1, 2'b11, 1'b0);
        tick(100);
        chk("t5_ok", 32'(link_ok), 0);
        chk("t5_spd", 32'(cfg_speed), 1);

        // Reset asserted during RESET and during DRAIN.
        set_raw(1'b1, 2'b10, 1'b1);
        tick(20);
        chk("t6_in_reset", 32'(cfg_speed), 2);
        rst = 1'b1;
        #2;
        chk("t6a_spd", 32'(cfg_speed), 0);
        chk("t6a_cnt", 32'(change_cnt), 0);
        tick(1);
        rst = 1'b0;
        tick(30);
        chk("t6_up", 32'(link_ok), 1);
        link_up_in = 1'b0;
        tx_busy    = 1'b1;
        tick(20);
        chk("t6_in_drain", 32'(change_cnt), 1);
        rst = 1'b1;
        #2;
        chk("t6b_mac", 32'(mac_rst), 1);
        chk("t6b_cnt", 32'(change_cnt), 0);
        tick(1);
        rst     = 1'b0;
        tx_busy = 1'b0;

        // Link flaps to saturate the change counter.
        link_up_in = 1'b1;
        tick(30);
        for (int i = 0; i < 300; i++) begin
            link_up_in = 1'b0;
            tick($urandom_range(18, 24));
            link_up_in = 1'b1;
            tick(30);
        end
        chk("t6_sat", 32'(change_cnt), 255);
        chk("t6_sat_up", 32'(link_ok), 1);

        // Random phase against the model.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 1)
                set_raw($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)));
            tx_busy = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) tick($urandom_range(50, 100));
            else tick($urandom_range(1, 30));
        end

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
